// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch and data ports.
// Data has priority unless it has won D_STREAK grants in a row while fetch was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no access in flight
  // BUSY_I | fetch access in flight, waiting MEM_LAT cycles for read data
  // BUSY_D | data access in flight, waiting MEM_LAT cycles for read data
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SK_W  = (D_STREAK < 2) ? 1 : $clog2(D_STREAK + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  lat_cnt;
  logic [SK_W-1:0]   streak;
  logic              done, can_grant, elig_i, elig_d, grant_i, grant_d;

  // done marks the last cycle of the access; the next access may be granted on its edge
  assign done      = (state != IDLE) && (lat_cnt == '0);
  assign can_grant = (state == IDLE) || done;
  assign elig_i    = if_req && (state != BUSY_I) && !if_ready;
  assign elig_d    = d_req  && (state != BUSY_D) && !d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant_i)      state_nxt = BUSY_I;
    else if (grant_d) state_nxt = BUSY_D;
    else if (done)    state_nxt = IDLE;
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (can_grant) begin
      if (elig_i && (!elig_d || streak == SK_W'(D_STREAK))) grant_i = 1'b1;
      else if (elig_d)                                      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt   <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en   <= grant_i || grant_d;
      if_ready <= done && (state == BUSY_I);
      d_ready  <= done && (state == BUSY_D);
      // capture uses the current mem_we, before a same-edge grant replaces it
      if (done && state == BUSY_I)            if_rdata <= mem_rdata;
      if (done && state == BUSY_D && !mem_we) d_rdata  <= mem_rdata;
      if (grant_i) begin
        mem_addr <= if_addr;
        mem_we   <= 1'b0;
        lat_cnt  <= CNT_W'(MEM_LAT);
        streak   <= '0;
      end else if (grant_d) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        lat_cnt   <= CNT_W'(MEM_LAT);
        if (!if_req)                           streak <= '0;
        else if (streak != SK_W'(D_STREAK))    streak <= streak + SK_W'(1);
      end else if (state != IDLE && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
    end
  end

endmodule
